// File: rtl/dispense_controller.sv
// Round-robin kiosk arbiter and litre-metered valve sequencer for the shared dispenser.
// Owns the three fluid stocks, with saturating refill merged with in-flight litre decrements.
module dispense_controller #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LITRE_CYCLES = 4,
  parameter logic [15:0] WATER_INIT   = 16'd100,
  parameter logic [15:0] JUICE_INIT   = 16'd80,
  parameter logic [15:0] CHEM_INIT    = 16'd60,
  localparam int unsigned IDW         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_fluid,
  input  logic [8*NUM_REQ-1:0] req_vol,
  input  logic                 abort,
  input  logic                 refill_valid,
  input  logic [1:0]           refill_fluid,
  input  logic [15:0]          refill_qty,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 valve_open,
  output logic [1:0]           valve_sel,
  output logic [7:0]           litres_done,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic [1:0]           status,
  output logic [15:0]          water_stock,
  output logic [15:0]          juice_stock,
  output logic [15:0]          chem_stock
);

  localparam int unsigned CW = (LITRE_CYCLES > 1) ? $clog2(LITRE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DISPENSE, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, idx, pick_idx;
  logic           pick_valid;
  logic [1:0]     fluid;
  logic [7:0]     vol;
  logic [CW-1:0]  cnt;
  logic [15:0]    sel_stock;
  logic           insufficient, litre_tick, last_litre;

  // First requester at or after ptr, wrapping; the modulo is unrolled as a conditional subtract.
  always_comb begin
    int unsigned cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_valid && req[cand[IDW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    case (fluid)
      2'd0:    sel_stock = water_stock;
      2'd1:    sel_stock = juice_stock;
      2'd2:    sel_stock = chem_stock;
      default: sel_stock = '0;
    endcase
  end

  assign insufficient = sel_stock < {8'd0, vol};
  assign litre_tick   = (state == S_DISPENSE) && (cnt == CW'(LITRE_CYCLES - 1));
  assign last_litre   = (litres_done + 8'd1) == vol;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (pick_valid) state_nxt = S_CHECK;
      S_CHECK:    if (fluid == 2'b11 || insufficient || vol == 8'd0) state_nxt = S_DONE;
                  else state_nxt = S_DISPENSE;
      S_DISPENSE: if (abort || (litre_tick && last_litre)) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state == S_CHECK) gnt[idx] = 1'b1;
    busy       = (state != S_IDLE);
    valve_open = (state == S_DISPENSE);
    valve_sel  = fluid;
    done       = (state == S_DONE);
    done_id    = (state == S_DONE) ? idx : '0;
  end

  // A refill and a litre decrement on the same fluid in the same cycle net out before saturation.
  function automatic logic [15:0] stock_next(input logic [15:0] cur, input logic add_en,
                                             input logic [15:0] qty, input logic dec);
    logic [16:0] sum;
    sum = {1'b0, cur} + (add_en ? {1'b0, qty} : 17'd0) - {16'd0, dec};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      idx         <= '0;
      fluid       <= '0;
      vol         <= '0;
      cnt         <= '0;
      litres_done <= '0;
      status      <= '0;
      water_stock <= WATER_INIT;
      juice_stock <= JUICE_INIT;
      chem_stock  <= CHEM_INIT;
    end else begin
      case (state)
        S_IDLE: if (pick_valid) begin
          idx   <= pick_idx;
          fluid <= req_fluid[{pick_idx, 1'b0} +: 2];
          vol   <= req_vol[{pick_idx, 3'b000} +: 8];
          ptr   <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        S_CHECK: begin
          litres_done <= '0;
          cnt         <= '0;
          if (fluid == 2'b11)   status <= 2'b10;
          else if (insufficient) status <= 2'b01;
          else                   status <= 2'b00;
        end
        S_DISPENSE: begin
          cnt <= litre_tick ? '0 : cnt + 1'b1;
          if (litre_tick) litres_done <= litres_done + 8'd1;
          if (abort) status <= 2'b11;
        end
        default: ;
      endcase
      water_stock <= stock_next(water_stock, refill_valid && refill_fluid == 2'd0, refill_qty,
                                litre_tick && fluid == 2'd0);
      juice_stock <= stock_next(juice_stock, refill_valid && refill_fluid == 2'd1, refill_qty,
                                litre_tick && fluid == 2'd1);
      chem_stock  <= stock_next(chem_stock, refill_valid && refill_fluid == 2'd2, refill_qty,
                                litre_tick && fluid == 2'd2);
    end
  end

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller with NUM_REQ=4, LITRE_CYCLES=4.
module tb_dispense_controller;
  logic        clk, reset;
  logic [3:0]  req;
  logic [7:0]  req_fluid;
  logic [31:0] req_vol;
  logic        abort, refill_valid;
  logic [1:0]  refill_fluid;
  logic [15:0] refill_qty;
  logic [3:0]  gnt;
  logic        busy, valve_open, done;
  logic [1:0]  valve_sel, status, done_id;
  logic [7:0]  litres_done;
  logic [15:0] water_stock, juice_stock, chem_stock;

  int n_checks = 0;
  int n_fail   = 0;

  int ob_gnt_pulses, ob_gnt_bad, ob_gnt_idx, ob_gnt_cycle, ob_valve, ob_valve_first;
  int ob_sel_bad, ob_done_cycle, ob_done_id, ob_status, ob_litres, ob_timeout;

  dispense_controller #(.NUM_REQ(4), .LITRE_CYCLES(4), .WATER_INIT(16'd100),
                        .JUICE_INIT(16'd80), .CHEM_INIT(16'd60)) dut (
    .clk(clk), .reset(reset), .req(req), .req_fluid(req_fluid), .req_vol(req_vol),
    .abort(abort), .refill_valid(refill_valid), .refill_fluid(refill_fluid),
    .refill_qty(refill_qty), .gnt(gnt), .busy(busy), .valve_open(valve_open),
    .valve_sel(valve_sel), .litres_done(litres_done), .done(done), .done_id(done_id),
    .status(status), .water_stock(water_stock), .juice_stock(juice_stock),
    .chem_stock(chem_stock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    reset = 1'b1; req = '0; abort = 1'b0; refill_valid = 1'b0;
    refill_fluid = '0; refill_qty = '0; req_fluid = '0; req_vol = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] f, input logic [7:0] v);
    req_fluid[2*i +: 2] = f;
    req_vol[8*i +: 8]   = v;
    req[i]              = 1'b1;
  endtask

  // Records what one order does; a kiosk drops its request once granted.
  task automatic observe(input int maxc, input logic [1:0] exp_sel);
    int c;
    bit fin;
    c = 0; fin = 0;
    ob_gnt_pulses = 0; ob_gnt_bad = 0; ob_gnt_idx = -1; ob_gnt_cycle = -1; ob_valve = 0;
    ob_valve_first = -1; ob_sel_bad = 0; ob_done_cycle = -1; ob_done_id = -1;
    ob_status = -1; ob_litres = -1;
    while (!fin && c < maxc) begin
      @(posedge clk); #1; c++;
      if (gnt != 4'b0) begin
        ob_gnt_pulses++;
        if ($countones(gnt) != 1) ob_gnt_bad++;
        ob_gnt_cycle = c;
        for (int i = 0; i < 4; i++) if (gnt[i]) begin ob_gnt_idx = i; req[i] = 1'b0; end
      end
      if (valve_open) begin
        if (ob_valve == 0) ob_valve_first = c;
        ob_valve++;
        if (valve_sel !== exp_sel) ob_sel_bad++;
      end
      if (done) begin
        fin = 1; ob_done_cycle = c; ob_done_id = int'(done_id);
        ob_status = int'(status); ob_litres = int'(litres_done);
      end
    end
    ob_timeout = fin ? 0 : 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (water_stock !== 16'd100) begin n_fail++; $display("FAIL reset_water: got %0d expected 100", water_stock); end
    n_checks++; if (juice_stock !== 16'd80) begin n_fail++; $display("FAIL reset_juice: got %0d expected 80", juice_stock); end
    n_checks++; if (chem_stock !== 16'd60) begin n_fail++; $display("FAIL reset_chem: got %0d expected 60", chem_stock); end
    n_checks++; if ({gnt, valve_open, done, busy, status, litres_done} !== 17'd0)
      begin n_fail++; $display("FAIL reset_outputs: got gnt=%b valve=%b done=%b busy=%b status=%b litres=%0d expected all 0",
                               gnt, valve_open, done, busy, status, litres_done); end
  endtask

  task automatic test_dispense();
    do_reset();
    set_req(0, 2'b00, 8'd3);
    observe(40, 2'b00);
    n_checks++; if (ob_timeout != 0) begin n_fail++; $display("FAIL disp_timeout: got no done expected done"); end
    n_checks++; if (ob_gnt_pulses != 1 || ob_gnt_bad != 0 || ob_gnt_idx != 0 || ob_gnt_cycle != 1)
      begin n_fail++; $display("FAIL disp_gnt: got pulses=%0d bad=%0d idx=%0d cyc=%0d expected 1/0/0/1",
                               ob_gnt_pulses, ob_gnt_bad, ob_gnt_idx, ob_gnt_cycle); end
    n_checks++; if (ob_valve != 12 || ob_valve_first != 2 || ob_sel_bad != 0)
      begin n_fail++; $display("FAIL disp_valve: got cycles=%0d first=%0d selbad=%0d expected 12/2/0",
                               ob_valve, ob_valve_first, ob_sel_bad); end
    n_checks++; if (ob_done_cycle != 14 || ob_done_id != 0 || ob_status != 0 || ob_litres != 3)
      begin n_fail++; $display("FAIL disp_done: got cyc=%0d id=%0d status=%0d litres=%0d expected 14/0/0/3",
                               ob_done_cycle, ob_done_id, ob_status, ob_litres); end
    n_checks++; if (water_stock !== 16'd97) begin n_fail++; $display("FAIL disp_water: got %0d expected 97", water_stock); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || status !== 2'b00 || litres_done !== 8'd3)
      begin n_fail++; $display("FAIL disp_hold: got done=%b busy=%b status=%b litres=%0d expected 0/0/00/3",
                               done, busy, status, litres_done); end
  endtask

  task automatic test_reject();
    do_reset();
    set_req(1, 2'b01, 8'd81);
    observe(10, 2'b01);
    n_checks++; if (ob_done_cycle != 2 || ob_status != 1 || ob_valve != 0 || ob_done_id != 1 || ob_litres != 0)
      begin n_fail++; $display("FAIL reject_stock: got cyc=%0d status=%0d valve=%0d id=%0d litres=%0d expected 2/1/0/1/0",
                               ob_done_cycle, ob_status, ob_valve, ob_done_id, ob_litres); end
    n_checks++; if (juice_stock !== 16'd80) begin n_fail++; $display("FAIL reject_juice: got %0d expected 80", juice_stock); end
    set_req(1, 2'b11, 8'd5);
    observe(10, 2'b11);
    n_checks++; if (ob_status != 2 || ob_valve != 0 || ob_timeout != 0)
      begin n_fail++; $display("FAIL reject_fluid: got status=%0d valve=%0d timeout=%0d expected 2/0/0",
                               ob_status, ob_valve, ob_timeout); end
    set_req(2, 2'b00, 8'd0);
    observe(10, 2'b00);
    n_checks++; if (ob_status != 0 || ob_valve != 0 || ob_litres != 0 || ob_done_id != 2 || water_stock !== 16'd100)
      begin n_fail++; $display("FAIL zero_vol: got status=%0d valve=%0d litres=%0d id=%0d water=%0d expected 0/0/0/2/100",
                               ob_status, ob_valve, ob_litres, ob_done_id, water_stock); end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 2, 0, 1, 1, 0};
    int got_order[6];
    do_reset();
    set_req(0, 2'b00, 8'd1); set_req(2, 2'b00, 8'd1);
    observe(20, 2'b00); got_order[0] = ob_done_id;
    observe(20, 2'b00); got_order[1] = ob_done_id;
    set_req(0, 2'b00, 8'd1); set_req(1, 2'b00, 8'd1);
    observe(20, 2'b00); got_order[2] = ob_done_id;
    observe(20, 2'b00); got_order[3] = ob_done_id;
    do_reset();
    set_req(0, 2'b00, 8'd1);
    observe(20, 2'b00);
    set_req(0, 2'b00, 8'd1); set_req(1, 2'b00, 8'd1);
    observe(20, 2'b00); got_order[4] = ob_done_id;
    observe(20, 2'b00); got_order[5] = ob_done_id;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (got_order[i] != exp_order[i])
        begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got_order[i], exp_order[i]); end
    end
  endtask

  task automatic test_refill();
    int c;
    do_reset();
    set_req(0, 2'b00, 8'd4);
    c = 0;
    while (c < 40) begin
      @(posedge clk); #1; c++;
      if (gnt[0]) req[0] = 1'b0;
      if (c == 17) begin
        n_checks++; if (water_stock !== 16'd97) begin n_fail++; $display("FAIL refill_pre: got %0d expected 97", water_stock); end
      end
      refill_valid = (c == 17); refill_fluid = 2'b00; refill_qty = 16'd10;
      if (done) break;
    end
    n_checks++; if (c != 18 || water_stock !== 16'd106 || litres_done !== 8'd4)
      begin n_fail++; $display("FAIL refill_merge: got cyc=%0d water=%0d litres=%0d expected 18/106/4", c, water_stock, litres_done); end
    refill_valid = 1'b1; refill_fluid = 2'b00; refill_qty = 16'hFFF0;
    @(posedge clk); #1;
    n_checks++; if (water_stock !== 16'hFFFF) begin n_fail++; $display("FAIL refill_sat: got %h expected ffff", water_stock); end
    refill_fluid = 2'b11; refill_qty = 16'd100;
    @(posedge clk); #1;
    n_checks++; if (water_stock !== 16'hFFFF || juice_stock !== 16'd80 || chem_stock !== 16'd60)
      begin n_fail++; $display("FAIL refill_invalid: got %0d/%0d/%0d expected 65535/80/60", water_stock, juice_stock, chem_stock); end
    refill_fluid = 2'b01; refill_qty = 16'd5;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    n_checks++; if (juice_stock !== 16'd85) begin n_fail++; $display("FAIL refill_juice: got %0d expected 85", juice_stock); end
  endtask

  task automatic test_abort_reset();
    int c, vcnt;
    do_reset();
    set_req(0, 2'b10, 8'd5);
    c = 0; vcnt = 0;
    while (c < 40) begin
      @(posedge clk); #1; c++;
      if (gnt[0]) req[0] = 1'b0;
      if (valve_open) vcnt++;
      abort = (c == 7);
      if (done) break;
    end
    abort = 1'b0;
    n_checks++; if (c != 8 || status !== 2'b11 || litres_done !== 8'd1 || chem_stock !== 16'd59)
      begin n_fail++; $display("FAIL abort_result: got cyc=%0d status=%b litres=%0d chem=%0d expected 8/11/1/59",
                               c, status, litres_done, chem_stock); end
    n_checks++; if (valve_open !== 1'b0 || vcnt != 6)
      begin n_fail++; $display("FAIL abort_valve: got open=%b cycles=%0d expected 0/6", valve_open, vcnt); end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || status !== 2'b11 || chem_stock !== 16'd59)
      begin n_fail++; $display("FAIL abort_idle: got busy=%b status=%b chem=%0d expected 0/11/59", busy, status, chem_stock); end
    set_req(0, 2'b10, 8'd5);
    c = 0;
    while (c < 10) begin
      @(posedge clk); #1; c++;
      if (gnt[0]) req[0] = 1'b0;
    end
    n_checks++; if (valve_open !== 1'b1 || chem_stock !== 16'd57)
      begin n_fail++; $display("FAIL midreset_pre: got open=%b chem=%0d expected 1/57", valve_open, chem_stock); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (valve_open !== 1'b0 || busy !== 1'b0 || water_stock !== 16'd100 ||
                    juice_stock !== 16'd80 || chem_stock !== 16'd60 || status !== 2'b00)
      begin n_fail++; $display("FAIL midreset: got open=%b busy=%b stocks=%0d/%0d/%0d status=%b expected 0/0/100/80/60/00",
                               valve_open, busy, water_stock, juice_stock, chem_stock, status); end
  endtask

  initial begin
    test_reset();
    test_dispense();
    test_reject();
    test_round_robin();
    test_refill();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
